// File: rtl/banked_rf_pkg.sv
// Shared types and helpers for the banked scalar register file.
// Contents: word width, top-level state enum, write-legality check and
// per-bank row lookup for an unaligned multi-word read.
package banked_rf_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    // Legal write: power-of-two length up to nb, start address aligned to it.
    function automatic logic is_legal_len(input int unsigned len, input int unsigned addr,
                                          input int unsigned nb);
        if (len == 0 || len > nb) return 1'b0;
        if ((len & (len - 1)) != 0) return 1'b0;
        return (addr & (len - 1)) == 0;
    endfunction

    // Row that bank 'bank' must supply for an nb-word read starting at addr (wraps at depth).
    function automatic int unsigned bank_row(input int unsigned addr, input int unsigned bank,
                                             input int unsigned nb, input int unsigned depth);
        int unsigned off;
        off = (bank + nb - (addr % nb)) % nb;
        return ((addr + off) % depth) / nb;
    endfunction

endpackage

// File: rtl/banked_rf_nr_nw_if.sv
// Read/write port bundle of the banked register file.
// master (client): drives rd_addr, wr_addr, wr_len, wr_data;
//                  receives ready, rd_data, wr_err, wr_conflict.
// slave  (file)  : the reverse.
interface banked_rf_nr_nw_if #(
    parameter int unsigned NUM_RD    = 3,
    parameter int unsigned NUM_WR    = 3,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned ADDR_W    = 9
);
    localparam int unsigned LEN_W = $clog2(NUM_BANKS + 1);

    logic                                                        ready;
    logic [NUM_RD-1:0][ADDR_W-1:0]                               rd_addr;
    logic [NUM_RD-1:0][NUM_BANKS-1:0][banked_rf_pkg::WORD_W-1:0] rd_data;
    logic [NUM_WR-1:0][ADDR_W-1:0]                               wr_addr;
    logic [NUM_WR-1:0][LEN_W-1:0]                                wr_len;
    logic [NUM_WR-1:0][NUM_BANKS-1:0][banked_rf_pkg::WORD_W-1:0] wr_data;
    logic [NUM_WR-1:0]                                           wr_err;
    logic                                                        wr_conflict;

    modport master (
        output rd_addr, wr_addr, wr_len, wr_data,
        input  ready, rd_data, wr_err, wr_conflict
    );

    modport slave (
        input  rd_addr, wr_addr, wr_len, wr_data,
        output ready, rd_data, wr_err, wr_conflict
    );

endinterface

// File: rtl/rf_bank_nr_nw.sv
// One bank: ROWS x 32-bit words, NUM_RD registered read ports, NUM_WR write
// ports (higher index wins), write-first forwarding and a row-clear port.
// Ports: clk, rst_n (sync, active-low), rd_row/rd_data per read port,
//        wr_en/wr_row/wr_data per write port, clr_en/clr_row for the sweep.
module rf_bank_nr_nw
    import banked_rf_pkg::*;
#(
    parameter int unsigned ROWS   = 128,
    parameter int unsigned NUM_RD = 3,
    parameter int unsigned NUM_WR = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_RD-1:0][$clog2(ROWS)-1:0] rd_row,
    output logic [NUM_RD-1:0][WORD_W-1:0]       rd_data,
    input  logic [NUM_WR-1:0]                   wr_en,
    input  logic [NUM_WR-1:0][$clog2(ROWS)-1:0] wr_row,
    input  logic [NUM_WR-1:0][WORD_W-1:0]       wr_data,
    input  logic                                clr_en,
    input  logic [$clog2(ROWS)-1:0]             clr_row
);
    logic [WORD_W-1:0]               mem [ROWS];
    logic [NUM_RD-1:0][WORD_W-1:0]   fwd_c;

    // Storage update; later ports overwrite earlier ones on the same row.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) mem[wr_row[p]] <= wr_data[p];
        end
        if (clr_en) mem[clr_row] <= '0;
    end

    // Write-first read value with the same port priority as the store.
    always_comb begin
        fwd_c = '0;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            fwd_c[r] = mem[rd_row[r]];
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && wr_row[p] == rd_row[r]) fwd_c[r] = wr_data[p];
            end
        end
    end

    // Read register; held at zero while the sweep runs.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_en) rd_data <= '0;
        else                  rd_data <= fwd_c;
    end

endmodule

// File: rtl/banked_rf_nr_nw.sv
// Banked 32-bit register file, NUM_RD unaligned NUM_BANKS-word reads and
// NUM_WR aligned writes, 1-cycle registered reads, write-first, zero sweep
// after reset.
// Ports: clk, rst_n (sync, active-low), bus (slave modport): rd_addr/rd_data,
//        wr_addr/wr_len/wr_data, wr_err, wr_conflict, ready.
module banked_rf_nr_nw
    import banked_rf_pkg::*;
#(
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned NUM_BANKS = 4,
    parameter int unsigned NUM_RD    = 3,
    parameter int unsigned NUM_WR    = 3,
    parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    banked_rf_nr_nw_if.slave   bus
);
    localparam int unsigned ROWS   = DEPTH / NUM_BANKS;
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned BANK_W = $clog2(NUM_BANKS);

    rf_state_e                                      state_q, state_d;
    logic [ROW_W-1:0]                               ptr_q, ptr_d;
    logic                                           clr_en_c;
    logic                                           ready_q;
    logic                                           run_c;
    logic [NUM_WR-1:0]                              acc_c, err_c;
    logic [NUM_WR-1:0][ROW_W-1:0]                   wrow_c;
    logic [NUM_WR-1:0][BANK_W-1:0]                  wbase_c;
    logic [NUM_BANKS-1:0][NUM_WR-1:0]               bwen_c;
    logic [NUM_BANKS-1:0][NUM_WR-1:0][WORD_W-1:0]   bwdata_c;
    logic [NUM_BANKS-1:0][NUM_RD-1:0][ROW_W-1:0]    brow_c;
    logic [NUM_BANKS-1:0][NUM_RD-1:0][WORD_W-1:0]   brd;
    logic [NUM_RD-1:0][BANK_W-1:0]                  rd_off_q;
    logic [NUM_WR-1:0]                              wr_err_q;
    logic                                           conflict_c, conflict_q;

    // Sweep FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= (state_d == RUN);
        end
    end

    // Sweep FSM next state: clear one row per cycle, then run.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        clr_en_c = 1'b0;
        if (state_q == INIT) begin
            clr_en_c = 1'b1;
            if (ptr_q == ROW_W'(ROWS - 1)) begin
                state_d = RUN;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + ROW_W'(1);
            end
        end
    end

    assign run_c = (state_q == RUN) && rst_n;

    // Per-port write legality; an aligned write never leaves its row.
    always_comb begin
        acc_c   = '0;
        err_c   = '0;
        wrow_c  = '0;
        wbase_c = '0;
        for (int unsigned p = 0; p < NUM_WR; p++) begin
            wrow_c[p]  = ROW_W'(bus.wr_addr[p] >> BANK_W);
            wbase_c[p] = BANK_W'(bus.wr_addr[p]);
            if (run_c && bus.wr_len[p] != '0) begin
                if (is_legal_len(32'(bus.wr_len[p]), 32'(bus.wr_addr[p]), NUM_BANKS))
                    acc_c[p] = 1'b1;
                else
                    err_c[p] = 1'b1;
            end
        end
    end

    // Route accepted write lanes to banks: bank b takes lane b - base.
    always_comb begin
        bwen_c   = '0;
        bwdata_c = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (acc_c[p] && b >= 32'(wbase_c[p]) &&
                    b < 32'(wbase_c[p]) + 32'(bus.wr_len[p])) begin
                    bwen_c[b][p]   = 1'b1;
                    bwdata_c[b][p] = bus.wr_data[p][BANK_W'(b - 32'(wbase_c[p]))];
                end
            end
        end
    end

    // Two writers on the same bank and row means the same word.
    always_comb begin
        conflict_c = 1'b0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                for (int unsigned q = p + 1; q < NUM_WR; q++) begin
                    if (bwen_c[b][p] && bwen_c[b][q] && wrow_c[p] == wrow_c[q])
                        conflict_c = 1'b1;
                end
            end
        end
    end

    // Row each bank supplies for each read port.
    always_comb begin
        brow_c = '0;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                brow_c[b][r] = ROW_W'(bank_row(32'(bus.rd_addr[r]), b, NUM_BANKS, DEPTH));
            end
        end
    end

    // Status pulses and the read rotation amount, aligned with bank read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_err_q   <= '0;
            conflict_q <= 1'b0;
            rd_off_q   <= '0;
        end else begin
            wr_err_q   <= err_c;
            conflict_q <= conflict_c;
            for (int unsigned r = 0; r < NUM_RD; r++) rd_off_q[r] <= BANK_W'(bus.rd_addr[r]);
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        rf_bank_nr_nw #(
            .ROWS   (ROWS),
            .NUM_RD (NUM_RD),
            .NUM_WR (NUM_WR)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .rd_row  (brow_c[b]),
            .rd_data (brd[b]),
            .wr_en   (bwen_c[b]),
            .wr_row  (wrow_c),
            .wr_data (bwdata_c[b]),
            .clr_en  (clr_en_c),
            .clr_row (ptr_q)
        );
    end

    // Rotate bank outputs so lane 0 is the addressed word.
    always_comb begin
        bus.rd_data = '0;
        for (int unsigned r = 0; r < NUM_RD; r++) begin
            for (int unsigned k = 0; k < NUM_BANKS; k++) begin
                bus.rd_data[r][k] = brd[BANK_W'(32'(rd_off_q[r]) + k)][r];
            end
        end
    end

    assign bus.ready       = ready_q;
    assign bus.wr_err      = wr_err_q;
    assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_banked_rf_nr_nw.sv
// Directed bench for banked_rf_nr_nw with default parameters.
module tb_banked_rf_nr_nw;
    localparam int unsigned NB  = 4;
    localparam int unsigned NRD = 3;
    localparam int unsigned NWR = 3;
    localparam int unsigned AW  = 9;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    banked_rf_nr_nw_if #(.NUM_RD(NRD), .NUM_WR(NWR), .NUM_BANKS(NB), .ADDR_W(AW)) bus ();

    banked_rf_nr_nw #(
        .DEPTH(512), .NUM_BANKS(NB), .NUM_RD(NRD), .NUM_WR(NWR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           wp;
        logic [2:0]   len;
        logic [8:0]   waddr;
        logic [127:0] wdata;
        logic [8:0]   raddr;
        logic [127:0] exp_rd;
        logic [2:0]   exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_addr = '0;
        bus.wr_addr = '0;
        bus.wr_len  = '0;
        bus.wr_data = '0;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sweep after reset release: ready low for 127 edges, high at the 128th;
    // reads stay zero and a write attempted throughout is ignored without error.
    task automatic sweep_check(input string tag);
        idle();
        bus.rd_addr[0] = 9'd100;
        bus.wr_len[0]  = 3'd1;
        bus.wr_addr[0] = 9'd0;
        bus.wr_data[0] = {96'd0, 32'hDEAD};
        bus.wr_len[1]  = 3'd3;
        bus.wr_addr[1] = 9'd8;
        for (int i = 1; i <= 128; i++) begin
            tick();
            check($sformatf("%s ready@%0d", tag, i), 128'(bus.ready), (i == 128) ? 128'd1 : 128'd0);
            check($sformatf("%s wr_err@%0d", tag, i), 128'(bus.wr_err), 128'd0);
            if (i == 64 || i == 128) check($sformatf("%s rd0@%0d", tag, i), bus.rd_data[0], 128'd0);
        end
        idle();
        bus.rd_addr[0] = 9'd0;
        tick();
        check({tag, " word0 after sweep"}, bus.rd_data[0], 128'd0);
    endtask

    initial begin
        vecs[0]  = '{0, 3'd4, 9'd508, {32'hD, 32'hC, 32'hB, 32'hA}, 9'd508, {32'hD, 32'hC, 32'hB, 32'hA}, 3'b000};
        vecs[1]  = '{1, 3'd2, 9'd0,   {64'd0, 32'hF, 32'hE},         9'd510, {32'hF, 32'hE, 32'hD, 32'hC}, 3'b000};
        vecs[2]  = '{0, 3'd0, 9'd0,   128'd0,                        9'd510, {32'hF, 32'hE, 32'hD, 32'hC}, 3'b000};
        vecs[3]  = '{2, 3'd1, 9'd7,   {96'd0, 32'h1234},             9'd6,   {32'h0, 32'h0, 32'h1234, 32'h0}, 3'b000};
        vecs[4]  = '{1, 3'd4, 9'd6,   {4{32'h99}},                   9'd4,   {32'h1234, 32'h0, 32'h0, 32'h0}, 3'b010};
        vecs[5]  = '{1, 3'd3, 9'd8,   {32'h0, {3{32'h88}}},          9'd8,   128'd0, 3'b010};
        vecs[6]  = '{0, 3'd5, 9'd0,   {4{32'h77}},                   9'd0,   {32'h0, 32'h0, 32'hF, 32'hE}, 3'b001};
        vecs[7]  = '{2, 3'd2, 9'd2,   {64'd0, 32'h22, 32'h21},       9'd0,   {32'h22, 32'h21, 32'hF, 32'hE}, 3'b000};
        vecs[8]  = '{0, 3'd1, 9'd511, {96'd0, 32'h77},               9'd511, {32'h21, 32'hF, 32'hE, 32'h77}, 3'b000};
        vecs[9]  = '{0, 3'd0, 9'd0,   128'd0,                        9'd3,   {32'h0, 32'h0, 32'h0, 32'h22}, 3'b000};
        vecs[10] = '{2, 3'd0, 9'd5,   {96'd0, 32'h55},               9'd7,   {32'h0, 32'h0, 32'h0, 32'h1234}, 3'b000};
        vecs[11] = '{0, 3'd4, 9'd12,  {32'h4, 32'h3, 32'h2, 32'h1},  9'd13,  {32'h0, 32'h4, 32'h3, 32'h2}, 3'b000};
        vecs[12] = '{2, 3'd2, 9'd9,   {64'd0, 32'hC2, 32'hC1},       9'd8,   128'd0, 3'b100};
        vecs[13] = '{1, 3'd2, 9'd10,  {64'd0, 32'hB2, 32'hB1},       9'd9,   {32'h1, 32'hB2, 32'hB1, 32'h0}, 3'b000};

        // Reset held for three edges.
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 128'(bus.ready), 128'd0);
        check("reset rd0", bus.rd_data[0], 128'd0);
        check("reset wr_err", 128'(bus.wr_err), 128'd0);
        check("reset conflict", 128'(bus.wr_conflict), 128'd0);
        rst_n = 1'b1;
        sweep_check("init");

        // Single-port vectors, one per cycle.
        for (int i = 0; i < 14; i++) begin
            idle();
            bus.rd_addr[0]        = vecs[i].raddr;
            bus.wr_len[vecs[i].wp]  = vecs[i].len;
            bus.wr_addr[vecs[i].wp] = vecs[i].waddr;
            bus.wr_data[vecs[i].wp] = vecs[i].wdata;
            tick();
            check($sformatf("vec%0d rd0", i), bus.rd_data[0], vecs[i].exp_rd);
            check($sformatf("vec%0d wr_err", i), 128'(bus.wr_err), 128'(vecs[i].exp_err));
            check($sformatf("vec%0d conflict", i), 128'(bus.wr_conflict), 128'd0);
        end

        // Write-first seen by other read ports in the same cycle.
        idle();
        bus.wr_len[0]  = 3'd1;
        bus.wr_addr[0] = 9'd7;
        bus.wr_data[0] = {96'd0, 32'h5678};
        bus.rd_addr[1] = 9'd6;
        bus.rd_addr[2] = 9'd5;
        tick();
        check("wfirst rd1", bus.rd_data[1], {32'h0, 32'h0, 32'h5678, 32'h0});
        check("wfirst rd2", bus.rd_data[2], {32'h0, 32'h5678, 32'h0, 32'h0});

        // Full overlap: port 2 beats port 0.
        idle();
        bus.wr_len[0]  = 3'd2;
        bus.wr_addr[0] = 9'd4;
        bus.wr_data[0] = {64'd0, 32'h22, 32'h11};
        bus.wr_len[2]  = 3'd2;
        bus.wr_addr[2] = 9'd4;
        bus.wr_data[2] = {64'd0, 32'h44, 32'h33};
        bus.rd_addr[0] = 9'd4;
        tick();
        check("conf1 flag", 128'(bus.wr_conflict), 128'd1);
        check("conf1 wr_err", 128'(bus.wr_err), 128'd0);
        check("conf1 fwd", bus.rd_data[0], {32'h5678, 32'h0, 32'h44, 32'h33});
        idle();
        bus.rd_addr[0] = 9'd4;
        tick();
        check("conf1 flag clear", 128'(bus.wr_conflict), 128'd0);
        check("conf1 stored", bus.rd_data[0], {32'h5678, 32'h0, 32'h44, 32'h33});

        // Partial overlap: port 1 wins word 5 only.
        idle();
        bus.wr_len[0]  = 3'd2;
        bus.wr_addr[0] = 9'd4;
        bus.wr_data[0] = {64'd0, 32'h77, 32'h66};
        bus.wr_len[1]  = 3'd1;
        bus.wr_addr[1] = 9'd5;
        bus.wr_data[1] = {96'd0, 32'h55};
        bus.rd_addr[0] = 9'd4;
        tick();
        check("conf2 flag", 128'(bus.wr_conflict), 128'd1);
        check("conf2 fwd", bus.rd_data[0], {32'h5678, 32'h0, 32'h55, 32'h66});

        // Same bank, different rows: not a conflict.
        idle();
        bus.wr_len[0]  = 3'd1;
        bus.wr_addr[0] = 9'd20;
        bus.wr_data[0] = {96'd0, 32'hAA};
        bus.wr_len[1]  = 3'd1;
        bus.wr_addr[1] = 9'd24;
        bus.wr_data[1] = {96'd0, 32'hBB};
        bus.rd_addr[0] = 9'd20;
        bus.rd_addr[1] = 9'd24;
        tick();
        check("rows flag", 128'(bus.wr_conflict), 128'd0);
        check("rows rd0", bus.rd_data[0], {96'd0, 32'hAA});
        check("rows rd1", bus.rd_data[1], {96'd0, 32'hBB});

        // One-cycle reset while running, then a full re-sweep.
        idle();
        bus.rd_addr[0] = 9'd4;
        rst_n = 1'b0;
        tick();
        check("midrst ready", 128'(bus.ready), 128'd0);
        check("midrst rd0", bus.rd_data[0], 128'd0);
        rst_n = 1'b1;
        sweep_check("resweep");
        idle();
        bus.rd_addr[0] = 9'd4;
        tick();
        check("resweep word4", bus.rd_data[0], 128'd0);
        bus.rd_addr[0] = 9'd508;
        tick();
        check("resweep word508", bus.rd_data[0], 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
